axis_argmax: RTL



---
 rtl/axis_argmax.sv | 120 ++++++++++++
 1 files changed

// File: rtl/axis_argmax.sv
// axis_argmax: AXI-stream argmax over one frame of NUM_CLASSES signed scores.
// Accepts NUM_CLASSES beats, then presents one result beat carrying the index
// of the largest score (lowest index on ties) and the score itself.
module axis_argmax #(
    parameter int WIDTH       = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [WIDTH-1:0] m_score,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter value of the final beat of a frame; one extra counter bit keeps
    // NUM_CLASSES == 2**IDX_WIDTH from wrapping before the last beat.
    localparam logic [IDX_WIDTH:0] LAST_CNT = (IDX_WIDTH+1)'(NUM_CLASSES - 1);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_WIDTH:0]      cnt;
    logic signed [WIDTH-1:0] max_score;
    logic [IDX_WIDTH-1:0]    idx;
    logic                    beat_xfer;
    logic                    result_xfer;

    // Strictly-greater signed compare: ties keep the earlier (lower) index.
    function automatic logic beats_max(input logic signed [WIDTH-1:0] cand,
                                       input logic signed [WIDTH-1:0] cur);
        return cand > cur;
    endfunction

    assign beat_xfer   = s_valid && s_ready;
    assign result_xfer = m_valid && m_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a frame ends on the beat whose counter equals LAST_CNT.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (beat_xfer) begin
                    next_state = (NUM_CLASSES == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_xfer && (cnt == LAST_CNT)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (result_xfer) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: the result registers drive the result beat directly, so
    // they stay stable for as long as DONE is held by backpressure.
    always_comb begin
        m_valid = (state == DONE);
        busy    = (state != IDLE);
        m_data  = WIDTH'(idx);
        m_score = max_score;
    end

    // s_ready is registered from the upcoming state, so it never depends
    // combinationally on s_valid and is low for the reset cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= (next_state != DONE);
        end
    end

    // Running maximum, its index, and the beat counter for the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            max_score <= '0;
            idx       <= '0;
        end else if (beat_xfer) begin
            if (state == IDLE) begin
                max_score <= $signed(s_data);
                idx       <= '0;
                cnt       <= (IDX_WIDTH+1)'(1);
            end else if (state == ACCUM) begin
                if (beats_max($signed(s_data), max_score)) begin
                    max_score <= $signed(s_data);
                    idx       <= cnt[IDX_WIDTH-1:0];
                end
                cnt <= cnt + (IDX_WIDTH+1)'(1);
            end
        end
    end

endmodule
